// File: rtl/sbox_block_sequencer.sv
// Feeds a NUM_BYTES block through one shared byte-wide S-box and reassembles the results in order.
// Optional: define SBOX_SEQ_STALL_CNT_EN to add the saturating stall_cnt output.
module sbox_block_sequencer #(
  parameter int unsigned NUM_BYTES    = 16,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   sbox_in_valid,
  input  logic                   sbox_in_ready,
  output logic [7:0]             sbox_in_data,
  input  logic                   sbox_out_valid,
  output logic                   sbox_out_ready,
  input  logic [7:0]             sbox_out_data,
  output logic                   busy
`ifdef SBOX_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(NUM_BYTES + 1);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] NB   = CW'(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
  localparam logic [IW-1:0] MI   = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [8*NUM_BYTES-1:0] blk;
  logic [CW-1:0]          issue_cnt;
  logic [CW-1:0]          collect_cnt;
  logic [IW-1:0]          inflight;
  logic [7:0]             issue_byte;
  logic                   issue_hs;
  logic                   ret_hs;

  always_comb begin
    issue_byte = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++)
      if (issue_cnt == CW'(i)) issue_byte = blk[8*i +: 8];
  end

  // Handshake outputs decode only registered state, so out_ready never reaches in_ready.
  assign in_ready       = (state == IDLE);
  assign out_valid      = (state == DONE);
  assign busy           = (state != IDLE);
  assign sbox_in_valid  = (state == RUN) && (issue_cnt < NB) && (inflight < MI);
  assign sbox_in_data   = sbox_in_valid ? issue_byte : '0;
  assign sbox_out_ready = (state == RUN) && (collect_cnt < NB);
  assign issue_hs       = sbox_in_valid && sbox_in_ready;
  assign ret_hs         = sbox_out_valid && sbox_out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      blk         <= '0;
      out_data    <= '0;
      issue_cnt   <= '0;
      collect_cnt <= '0;
      inflight    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            blk         <= in_data;
            issue_cnt   <= '0;
            collect_cnt <= '0;
            inflight    <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (issue_hs) issue_cnt <= issue_cnt + CW'(1);
          if (ret_hs) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++)
              if (collect_cnt == CW'(i)) out_data[8*i +: 8] <= sbox_out_data;
            collect_cnt <= collect_cnt + CW'(1);
            if (collect_cnt == LAST) state <= DONE;
          end
          if (issue_hs && !ret_hs)      inflight <= inflight + IW'(1);
          else if (!issue_hs && ret_hs) inflight <= inflight - IW'(1);
        end
        DONE: begin
          if (out_ready) begin
            issue_cnt   <= '0;
            collect_cnt <= '0;
            inflight    <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SBOX_SEQ_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= '0;
    else if (sbox_in_valid && !sbox_in_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sbox_block_sequencer.sv
// Randomised bench for sbox_block_sequencer with a queue-based S-box responder and block-level reference.
module tb_sbox_block_sequencer;
  localparam int unsigned N  = 16;
  localparam int unsigned MI = 4;

  logic           clock = 1'b0;
  logic           reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [8*N-1:0] in_data, out_data;
  logic           sbox_in_valid, sbox_in_ready, sbox_out_valid, sbox_out_ready;
  logic [7:0]     sbox_in_data, sbox_out_data;
`ifdef SBOX_SEQ_STALL_CNT_EN
  logic [31:0]    stall_cnt;
  logic [31:0]    stall_m;
`endif

  always #5 clock = ~clock;

  sbox_block_sequencer #(.NUM_BYTES(N), .MAX_INFLIGHT(MI)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sbox_in_valid(sbox_in_valid), .sbox_in_ready(sbox_in_ready), .sbox_in_data(sbox_in_data),
    .sbox_out_valid(sbox_out_valid), .sbox_out_ready(sbox_out_ready), .sbox_out_data(sbox_out_data),
    .busy(busy)
`ifdef SBOX_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct { logic [7:0] b; int unsigned rdy; } ent_t;

  int unsigned    checks = 0, errors = 0, cyc = 0;
  logic [7:0]     sbox_tab [256];
  ent_t           sq [$];
  int unsigned    sb_lat = 1, sb_rdy_pct = 100, sb_ret_pct = 100, or_pct = 100;
  int unsigned    done_hold = 0, stall_start = 0;
  logic           reset_d, in_valid_d;
  logic [8*N-1:0] in_data_d;
  int unsigned    phase = 0, issued = 0, collected = 0, acc_cyc = 0;
  int unsigned    nordy_left = 0, hold_left = 0, done_len = 0, blocks_done = 0;
  logic [8*N-1:0] m_blk, m_exp, last_out;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [8*N-1:0] sub_block(input logic [8*N-1:0] blk);
    logic [8*N-1:0] r;
    for (int k = 0; k < N; k++) r[8*k +: 8] = sbox_tab[blk[8*k +: 8]];
    return r;
  endfunction

  // FIPS-197 strings list byte 0 first; the port puts byte 0 in the low bits.
  function automatic logic [127:0] swap(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = v[127-8*k -: 8];
    return r;
  endfunction

  task automatic step();
    logic exp_siv, exp_sor, iss, ret;
    logic [2:0] exp_ctl;
    ent_t e;
    @(negedge clock);
    reset    = reset_d;
    in_valid = in_valid_d;
    in_data  = in_data_d;
    sbox_out_valid = (sq.size() > 0) && (sq[0].rdy <= cyc) && ($urandom_range(99) < sb_ret_pct);
    sbox_out_data  = sbox_out_valid ? sbox_tab[sq[0].b] : 8'($urandom);
    if (nordy_left > 0) begin sbox_in_ready = 1'b0; nordy_left--; end
    else sbox_in_ready = ($urandom_range(99) < sb_rdy_pct);
    if (phase == 2 && hold_left > 0) begin out_ready = 1'b0; hold_left--; end
    else out_ready = ($urandom_range(99) < or_pct);
    #1;
    exp_siv = (phase == 1) && (issued < N) && (sq.size() < MI);
    exp_sor = (phase == 1) && (collected < N);
    if (!reset_d) begin
      exp_ctl = (phase == 0) ? 3'b100 : (phase == 1) ? 3'b001 : 3'b011;
      check_eq("ready_valid_busy", {in_ready, out_valid, busy}, exp_ctl);
      check_eq("sbox_valid_ready", {sbox_in_valid, sbox_out_ready}, {exp_siv, exp_sor});
      if (exp_siv) check_eq("sbox_in_data", sbox_in_data, m_blk[8*issued +: 8]);
      if (phase == 2) check_eq("out_data", out_data, m_exp);
`ifdef SBOX_SEQ_STALL_CNT_EN
      if (exp_siv && !sbox_in_ready) stall_m++;
`endif
      iss = exp_siv && sbox_in_ready;
      ret = sbox_out_valid && exp_sor;
      if (ret) begin void'(sq.pop_front()); collected++; end
      if (iss) begin
        e.b = m_blk[8*issued +: 8]; e.rdy = cyc + sb_lat;
        sq.push_back(e); issued++;
      end
      case (phase)
        0: if (in_valid_d) begin
             m_blk = in_data_d; m_exp = sub_block(in_data_d);
             issued = 0; collected = 0; acc_cyc = cyc; nordy_left = stall_start; phase = 1;
           end
        1: if (collected == N) begin
             phase = 2; done_len = 0; hold_left = done_hold;
             if (sb_lat == 1 && sb_rdy_pct == 100 && sb_ret_pct == 100 && stall_start == 0)
               check_eq("latency", cyc + 1 - acc_cyc, N + 2);
           end
        default: begin
             done_len++;
             if (out_ready) begin last_out = out_data; phase = 0; blocks_done++; end
           end
      endcase
    end else begin
      phase = 0; issued = 0; collected = 0; nordy_left = 0; hold_left = 0;
      sq.delete();
`ifdef SBOX_SEQ_STALL_CNT_EN
      stall_m = '0;
`endif
    end
    @(posedge clock);
    cyc++;
  endtask

  task automatic run_block(input logic [8*N-1:0] blk);
    int unsigned start, n;
    start = blocks_done;
    in_valid_d = 1'b1; in_data_d = blk;
    n = 0;
    while (phase == 0 && n < 50) begin step(); n++; end
    check_eq("accept_bound", n < 50, 1'b1);
    in_valid_d = 1'b0; in_data_d = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (blocks_done == start && n < 4000) begin step(); n++; end
    check_eq("block_bound", blocks_done - start, 1);
  endtask

  task automatic check_reset_vals();
    #2;
    check_eq("rst_ctl", {in_ready, out_valid, sbox_in_valid, sbox_out_ready, busy}, 5'b10000);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_sbox_in_data", sbox_in_data, 8'h00);
`ifdef SBOX_SEQ_STALL_CNT_EN
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    sbox_in_ready = 1'b0; sbox_out_valid = 1'b0; sbox_out_data = '0;
    reset_d = 1'b1; in_valid_d = 1'b0; in_data_d = '0;
`ifdef SBOX_SEQ_STALL_CNT_EN
    stall_m = '0;
`endif
    step(); step();
    check_reset_vals();
    reset_d = 1'b0;
    step();

    run_block('0);
    check_eq("zero_block", last_out, {N{8'h63}});

    run_block(swap(128'h193de3bea0f4e22b9ac68d2ae9f84808));
    check_eq("fips_round1", last_out, swap(128'hd42711aee0bf98f1b8b45de51e415230));

    sb_lat = 10;
    run_block({$urandom, $urandom, $urandom, $urandom});
    sb_lat = 1;

    done_hold = 20;
    run_block({$urandom, $urandom, $urandom, $urandom});
    check_eq("done_hold_len", done_len, 21);
    done_hold = 0;

    for (int b = 0; b < 25; b++) begin
      sb_lat     = $urandom_range(1, 8);
      sb_rdy_pct = $urandom_range(40, 100);
      sb_ret_pct = $urandom_range(40, 100);
      or_pct     = $urandom_range(30, 100);
      run_block({$urandom, $urandom, $urandom, $urandom});
    end
    sb_lat = 1; sb_rdy_pct = 100; sb_ret_pct = 100; or_pct = 100;
`ifdef SBOX_SEQ_STALL_CNT_EN
    step();
    check_eq("stall_cnt_accum", stall_cnt, stall_m);
`endif

    in_valid_d = 1'b1; in_data_d = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 60 && !(phase == 1 && issued >= 7); n++) begin
      step();
      in_valid_d = 1'b0;
    end
    check_eq("issued_before_reset", issued, 7);
    reset_d = 1'b1;
    step();
    reset_d = 1'b0;
    check_reset_vals();

    stall_start = 5;
    run_block({N{8'h53}});
    check_eq("after_reset_block", last_out, {N{8'hED}});
    stall_start = 0;
`ifdef SBOX_SEQ_STALL_CNT_EN
    check_eq("stall_cnt_5", stall_cnt, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
